usb_tx_sequencer: RTL



---
 rtl/usb_tx_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/usb_tx_sequencer.sv
// Packet-level USB TX field sequencer: SYNC, PID, [DATA, CRC5/CRC16], EOP.
// Optional per-field watchdog is built when USB_TX_SEQ_WATCHDOG_EN is defined.
module usb_tx_sequencer #(
    parameter int unsigned EOP_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic [1:0] pkt_type,
    input  logic       sync_bits_transmitted,
    input  logic       pid_bits_transmitted,
    input  logic       data_bits_transmitted,
    input  logic       crc5_bits_transmitted,
    input  logic       crc16_bits_transmitted,
    output logic       sync_transmitting,
    output logic       pid_transmitting,
    output logic       data_transmitting,
    output logic       crc5_transmitting,
    output logic       crc16_transmitting,
    output logic       eop_active,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int unsigned EopW = $clog2(EOP_CYCLES + 1);
    localparam logic [EopW-1:0] EopLast = EopW'(EOP_CYCLES - 1);

    localparam logic [1:0] TypeHandshake = 2'b00;
    localparam logic [1:0] TypeToken     = 2'b01;
    localparam logic [1:0] TypeIllegal   = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StPid,
        StData,
        StCrc,
        StEop
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      type_q, type_d;
    logic [EopW-1:0] eop_cnt_q, eop_cnt_d;
    logic            error_q, error_d;
    logic            field_pulse;
    logic            in_field;

    // Only the pulse belonging to the field currently on the wire may advance.
    always_comb begin
        field_pulse = 1'b0;
        in_field    = 1'b1;
        unique case (state_q)
            StSync:  field_pulse = sync_bits_transmitted;
            StPid:   field_pulse = pid_bits_transmitted;
            StData:  field_pulse = data_bits_transmitted;
            StCrc:   field_pulse = (type_q == TypeToken) ? crc5_bits_transmitted
                                                         : crc16_bits_transmitted;
            default: in_field = 1'b0;
        endcase
    end

`ifdef USB_TX_SEQ_WATCHDOG_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

    logic [WdW-1:0] wd_q, wd_d;
    logic           wd_expire;

    assign wd_expire = in_field && !field_pulse && (wd_q == WdLast);
`else
    logic wd_expire;
    logic unused_timeout;

    assign wd_expire      = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        eop_cnt_d = '0;
        error_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (pkt_type == TypeIllegal) begin
                        error_d = 1'b1;
                    end else begin
                        type_d  = pkt_type;
                        state_d = StSync;
                    end
                end
            end
            StSync: if (field_pulse) state_d = StPid;
            StPid: begin
                if (field_pulse) state_d = (type_q == TypeHandshake) ? StEop : StData;
            end
            StData: if (field_pulse) state_d = StCrc;
            StCrc:  if (field_pulse) state_d = StEop;
            StEop: begin
                if (eop_cnt_q == EopLast) state_d = StIdle;
                else                      eop_cnt_d = eop_cnt_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase
        // Abort without EOP; a coincident field pulse already suppressed wd_expire.
        if (wd_expire) begin
            state_d = StIdle;
            error_d = 1'b1;
        end
    end

`ifdef USB_TX_SEQ_WATCHDOG_EN
    always_comb begin
        wd_d = '0;
        if (in_field && (state_d == state_q)) wd_d = wd_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) wd_q <= '0;
        else        wd_q <= wd_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q   <= StIdle;
            type_q    <= 2'b00;
            eop_cnt_q <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            type_q    <= type_d;
            eop_cnt_q <= eop_cnt_d;
            error_q   <= error_d;
        end
    end

    assign sync_transmitting  = (state_q == StSync);
    assign pid_transmitting   = (state_q == StPid);
    assign data_transmitting  = (state_q == StData);
    assign crc5_transmitting  = (state_q == StCrc) && (type_q == TypeToken);
    assign crc16_transmitting = (state_q == StCrc) && (type_q != TypeToken);
    assign eop_active         = (state_q == StEop);
    assign busy               = (state_q != StIdle);
    assign done               = (state_q == StEop) && (eop_cnt_q == EopLast);
    assign error              = error_q;

endmodule
